// File: rtl/l1tlb_l2req_pkg.sv
// Shared types for the L1TLB side of the L1TLB<->L2TLB interface.
package l1tlb_l2req_pkg;

    localparam int SC_LADDRBITS  = 50;
    localparam int L1TLB_RIDBITS = 4;
    localparam int VPAGE_W       = 11;
    localparam int HPADDR_W      = 11;
    localparam int PPADDR_W      = 3;
    localparam int DCTLBE_W      = 13;

    typedef struct packed {
        logic [L1TLB_RIDBITS-1:0] rid;
        logic [SC_LADDRBITS-1:0]  laddr;
    } I_l1tlbtol2tlb_req_type;

    typedef struct packed {
        logic [L1TLB_RIDBITS-1:0] rid;
        logic [HPADDR_W-1:0]      hpaddr;
        logic [PPADDR_W-1:0]      ppaddr;
        logic [DCTLBE_W-1:0]      dctlbe;
    } I_l2tlbtol1tlb_ack_type;

    typedef struct packed {
        logic [HPADDR_W-1:0] hpaddr;
    } I_l2tlbtol1tlb_snoop_type;

    typedef struct packed {
        logic [HPADDR_W-1:0] hpaddr;
    } I_l1tlbtol2tlb_sack_type;

    typedef enum logic [1:0] {
        E_FREE,
        E_PEND,
        E_WAIT
    } entry_state_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_INV,
        S_SACK
    } snoop_state_t;

    function automatic logic [SC_LADDRBITS-1:0] vpage_to_laddr(input logic [VPAGE_W-1:0] vpage);
        logic [SC_LADDRBITS-1:0] laddr;
        laddr        = '0;
        laddr[22:12] = vpage;
        return laddr;
    endfunction

endpackage

// File: rtl/l1tlb_l2req_fflop.sv
// Single-entry registered valid/retry stage used on the req and sack outputs.
module l1tlb_l2req_fflop #(
    parameter type T = logic [7:0]
) (
    input  logic clk,
    input  logic reset,
    input  logic din_valid,
    output logic din_retry,
    input  T     din,
    output logic dout_valid,
    input  logic dout_retry,
    output T     dout
);

    assign din_retry = dout_valid & dout_retry;

    always_ff @(posedge clk) begin
        if (reset) begin
            dout_valid <= 1'b0;
        end else if (!din_retry) begin
            dout_valid <= din_valid;
        end
        if (!din_retry && din_valid) begin
            dout <= din;
        end
    end

endmodule

// File: rtl/l1tlb_rid_table.sv
// Per-rid entry state, stale bits and vpage storage with free/pend priority encoders.
module l1tlb_rid_table
    import l1tlb_l2req_pkg::*;
#(
    parameter int NUM_RID = 4,
    parameter int RID_W   = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [VPAGE_W-1:0] lookup_vpage,
    output logic               merge_hit,
    output logic               any_free,
    output logic [RID_W-1:0]   free_idx,
    output logic               any_pend,
    output logic [RID_W-1:0]   pend_idx,
    output logic [VPAGE_W-1:0] pend_vpage,
    input  logic [RID_W-1:0]   ack_idx,
    output entry_state_t       ack_state,
    output logic               ack_stale,
    output logic [VPAGE_W-1:0] ack_vpage,
    input  logic               alloc,
    input  logic [VPAGE_W-1:0] alloc_vpage,
    input  logic               issue,
    input  logic               fill_done,
    input  logic               replay,
    input  logic               snoop_accept
);

    entry_state_t       state     [NUM_RID];
    entry_state_t       state_nxt [NUM_RID];
    logic [NUM_RID-1:0] stale;
    logic [VPAGE_W-1:0] vpage     [NUM_RID];

    always_comb begin
        any_free  = 1'b0;
        free_idx  = '0;
        any_pend  = 1'b0;
        pend_idx  = '0;
        merge_hit = 1'b0;
        for (int unsigned i = 0; i < NUM_RID; i++) begin
            if (!any_free && state[i] == E_FREE) begin
                any_free = 1'b1;
                free_idx = RID_W'(i);
            end
            if (!any_pend && state[i] == E_PEND) begin
                any_pend = 1'b1;
                pend_idx = RID_W'(i);
            end
            if (state[i] != E_FREE && !stale[i] && vpage[i] == lookup_vpage) begin
                merge_hit = 1'b1;
            end
        end
        pend_vpage = vpage[pend_idx];
    end

    always_comb begin
        ack_state = E_FREE;
        ack_stale = 1'b0;
        ack_vpage = '0;
        if (int'(ack_idx) < NUM_RID) begin
            ack_state = state[ack_idx];
            ack_stale = stale[ack_idx];
            ack_vpage = vpage[ack_idx];
        end
    end

    // Allocation, issue and ack always target different entries, so the updates never collide.
    always_comb begin
        state_nxt = state;
        if (alloc)     state_nxt[free_idx] = E_PEND;
        if (issue)     state_nxt[pend_idx] = E_WAIT;
        if (fill_done) state_nxt[ack_idx]  = E_FREE;
        if (replay)    state_nxt[ack_idx]  = E_PEND;
    end

    // Stale marks whatever will be WAIT after this edge, so a same-cycle fill escapes it
    // and a same-cycle PEND->WAIT move is caught.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_RID; i++) begin
                state[i] <= E_FREE;
            end
            stale <= '0;
        end else begin
            state <= state_nxt;
            for (int unsigned i = 0; i < NUM_RID; i++) begin
                if (snoop_accept && state_nxt[i] == E_WAIT) begin
                    stale[i] <= 1'b1;
                end else if (replay && ack_idx == RID_W'(i)) begin
                    stale[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (alloc) begin
            vpage[free_idx] <= alloc_vpage;
        end
    end

endmodule

// File: rtl/l1tlb_l2req.sv
// L1TLB endpoint: turns lookup misses into rid-tagged L2TLB requests, returns fills,
// and services L2TLB snoops by invalidating the array before acknowledging.
module l1tlb_l2req
    import l1tlb_l2req_pkg::*;
#(
    parameter int NUM_RID = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     miss_valid,
    output logic                     miss_retry,
    input  logic [SC_LADDRBITS-1:0]  miss_laddr,
    output logic                     l1tlbtol2tlb_req_valid,
    input  logic                     l1tlbtol2tlb_req_retry,
    output I_l1tlbtol2tlb_req_type   l1tlbtol2tlb_req,
    input  logic                     l2tlbtol1tlb_ack_valid,
    output logic                     l2tlbtol1tlb_ack_retry,
    input  I_l2tlbtol1tlb_ack_type   l2tlbtol1tlb_ack,
    output logic                     fill_valid,
    input  logic                     fill_retry,
    output logic [VPAGE_W-1:0]       fill_vpage,
    output logic [HPADDR_W-1:0]      fill_hpaddr,
    output logic [PPADDR_W-1:0]      fill_ppaddr,
    output logic [DCTLBE_W-1:0]      fill_dctlbe,
    input  logic                     l2tlbtol1tlb_snoop_valid,
    output logic                     l2tlbtol1tlb_snoop_retry,
    input  I_l2tlbtol1tlb_snoop_type l2tlbtol1tlb_snoop,
    output logic                     inv_valid,
    input  logic                     inv_retry,
    output logic [HPADDR_W-1:0]      inv_hpaddr,
    output logic                     l1tlbtol2tlb_sack_valid,
    input  logic                     l1tlbtol2tlb_sack_retry,
    output I_l1tlbtol2tlb_sack_type  l1tlbtol2tlb_sack,
    output logic                     err_ack
);

    localparam int RID_W = (NUM_RID > 1) ? $clog2(NUM_RID) : 1;

    logic [VPAGE_W-1:0]     miss_vpage;
    logic                   merge_hit, any_free, any_pend, alloc;
    logic [RID_W-1:0]       free_idx, pend_idx, ack_idx;
    logic [VPAGE_W-1:0]     pend_vpage, ack_vpage;
    entry_state_t           ack_state;
    logic                   ack_stale, ack_rid_ok, is_wait, is_fill, is_replay;
    logic                   ack_fire, fill_done, replay, ack_err;
    logic                   req_din_retry, sack_din_valid, sack_din_retry;
    I_l1tlbtol2tlb_req_type  req_din;
    I_l1tlbtol2tlb_sack_type sack_din;
    snoop_state_t           snp_state, snp_nxt;
    logic [HPADDR_W-1:0]    snp_hpaddr;
    logic                   snp_idle, snoop_accept;
    logic                   unused_laddr_bits;

    assign miss_vpage        = miss_laddr[22:12];
    assign unused_laddr_bits = ^{miss_laddr[SC_LADDRBITS-1:23], miss_laddr[11:0]};

    assign alloc      = miss_valid & ~merge_hit & any_free;
    assign miss_retry = miss_valid & ~merge_hit & ~any_free;

    assign ack_idx    = l2tlbtol1tlb_ack.rid[RID_W-1:0];
    assign ack_rid_ok = l2tlbtol1tlb_ack.rid < L1TLB_RIDBITS'(NUM_RID);
    assign is_wait    = ack_rid_ok & (ack_state == E_WAIT);
    assign is_fill    = is_wait & ~ack_stale;
    assign is_replay  = is_wait & ack_stale;

    assign snp_idle     = (snp_state == S_IDLE);
    assign snoop_accept = l2tlbtol1tlb_snoop_valid & snp_idle;

    // Every ack waits out an in-progress snoop so nothing lands between invalidate and sack.
    assign l2tlbtol1tlb_ack_retry = ~snp_idle | (is_fill & fill_retry);
    assign ack_fire  = l2tlbtol1tlb_ack_valid & ~l2tlbtol1tlb_ack_retry;
    assign fill_done = ack_fire & is_fill;
    assign replay    = ack_fire & is_replay;
    assign ack_err   = ack_fire & ~is_wait;

    assign fill_valid  = l2tlbtol1tlb_ack_valid & snp_idle & is_fill;
    assign fill_vpage  = ack_vpage;
    assign fill_hpaddr = l2tlbtol1tlb_ack.hpaddr;
    assign fill_ppaddr = l2tlbtol1tlb_ack.ppaddr;
    assign fill_dctlbe = l2tlbtol1tlb_ack.dctlbe;

    l1tlb_rid_table #(
        .NUM_RID (NUM_RID),
        .RID_W   (RID_W)
    ) u_rid_table (
        .clk          (clk),
        .reset        (reset),
        .lookup_vpage (miss_vpage),
        .merge_hit    (merge_hit),
        .any_free     (any_free),
        .free_idx     (free_idx),
        .any_pend     (any_pend),
        .pend_idx     (pend_idx),
        .pend_vpage   (pend_vpage),
        .ack_idx      (ack_idx),
        .ack_state    (ack_state),
        .ack_stale    (ack_stale),
        .ack_vpage    (ack_vpage),
        .alloc        (alloc),
        .alloc_vpage  (miss_vpage),
        .issue        (any_pend & ~req_din_retry),
        .fill_done    (fill_done),
        .replay       (replay),
        .snoop_accept (snoop_accept)
    );

    always_comb begin
        req_din.rid   = L1TLB_RIDBITS'(pend_idx);
        req_din.laddr = vpage_to_laddr(pend_vpage);
    end

    l1tlb_l2req_fflop #(
        .T (I_l1tlbtol2tlb_req_type)
    ) u_req_ff (
        .clk        (clk),
        .reset      (reset),
        .din_valid  (any_pend),
        .din_retry  (req_din_retry),
        .din        (req_din),
        .dout_valid (l1tlbtol2tlb_req_valid),
        .dout_retry (l1tlbtol2tlb_req_retry),
        .dout       (l1tlbtol2tlb_req)
    );

    always_comb begin
        snp_nxt                  = snp_state;
        l2tlbtol1tlb_snoop_retry = 1'b0;
        inv_valid                = 1'b0;
        sack_din_valid           = 1'b0;
        case (snp_state)
            S_IDLE: begin
                if (l2tlbtol1tlb_snoop_valid) snp_nxt = S_INV;
            end
            S_INV: begin
                l2tlbtol1tlb_snoop_retry = 1'b1;
                inv_valid                = 1'b1;
                if (!inv_retry) snp_nxt = S_SACK;
            end
            S_SACK: begin
                l2tlbtol1tlb_snoop_retry = 1'b1;
                sack_din_valid           = 1'b1;
                if (!sack_din_retry) snp_nxt = S_IDLE;
            end
            default: snp_nxt = S_IDLE;
        endcase
    end

    assign inv_hpaddr      = snp_hpaddr;
    assign sack_din.hpaddr = snp_hpaddr;

    always_ff @(posedge clk) begin
        if (reset) begin
            snp_state <= S_IDLE;
            err_ack   <= 1'b0;
        end else begin
            snp_state <= snp_nxt;
            err_ack   <= ack_err;
        end
        if (snoop_accept) begin
            snp_hpaddr <= l2tlbtol1tlb_snoop.hpaddr;
        end
    end

    l1tlb_l2req_fflop #(
        .T (I_l1tlbtol2tlb_sack_type)
    ) u_sack_ff (
        .clk        (clk),
        .reset      (reset),
        .din_valid  (sack_din_valid),
        .din_retry  (sack_din_retry),
        .din        (sack_din),
        .dout_valid (l1tlbtol2tlb_sack_valid),
        .dout_retry (l1tlbtol2tlb_sack_retry),
        .dout       (l1tlbtol2tlb_sack)
    );

endmodule

// File: tb/tb_l1tlb_l2req.sv
// Directed bench for l1tlb_l2req with queue scoreboards on the req, fill, inv and sack channels.
module tb_l1tlb_l2req;
    import l1tlb_l2req_pkg::*;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     miss_valid;
    logic                     miss_retry;
    logic [SC_LADDRBITS-1:0]  miss_laddr;
    logic                     req_valid;
    logic                     req_retry;
    I_l1tlbtol2tlb_req_type   req;
    logic                     ack_valid;
    logic                     ack_retry;
    I_l2tlbtol1tlb_ack_type   ack;
    logic                     fill_valid;
    logic                     fill_retry;
    logic [VPAGE_W-1:0]       fill_vpage;
    logic [HPADDR_W-1:0]      fill_hpaddr;
    logic [PPADDR_W-1:0]      fill_ppaddr;
    logic [DCTLBE_W-1:0]      fill_dctlbe;
    logic                     snoop_valid;
    logic                     snoop_retry;
    I_l2tlbtol1tlb_snoop_type snoop;
    logic                     inv_valid;
    logic                     inv_retry;
    logic [HPADDR_W-1:0]      inv_hpaddr;
    logic                     sack_valid;
    logic                     sack_retry;
    I_l1tlbtol2tlb_sack_type  sack;
    logic                     err_ack;

    l1tlb_l2req #(.NUM_RID(4)) dut (
        .clk                      (clk),
        .reset                    (reset),
        .miss_valid               (miss_valid),
        .miss_retry               (miss_retry),
        .miss_laddr               (miss_laddr),
        .l1tlbtol2tlb_req_valid   (req_valid),
        .l1tlbtol2tlb_req_retry   (req_retry),
        .l1tlbtol2tlb_req         (req),
        .l2tlbtol1tlb_ack_valid   (ack_valid),
        .l2tlbtol1tlb_ack_retry   (ack_retry),
        .l2tlbtol1tlb_ack         (ack),
        .fill_valid               (fill_valid),
        .fill_retry               (fill_retry),
        .fill_vpage               (fill_vpage),
        .fill_hpaddr              (fill_hpaddr),
        .fill_ppaddr              (fill_ppaddr),
        .fill_dctlbe              (fill_dctlbe),
        .l2tlbtol1tlb_snoop_valid (snoop_valid),
        .l2tlbtol1tlb_snoop_retry (snoop_retry),
        .l2tlbtol1tlb_snoop       (snoop),
        .inv_valid                (inv_valid),
        .inv_retry                (inv_retry),
        .inv_hpaddr               (inv_hpaddr),
        .l1tlbtol2tlb_sack_valid  (sack_valid),
        .l1tlbtol2tlb_sack_retry  (sack_retry),
        .l1tlbtol2tlb_sack        (sack),
        .err_ack                  (err_ack)
    );

    always #5 clk = ~clk;

    typedef struct { logic [3:0] rid; logic [10:0] vpage; } req_exp_t;
    typedef struct { logic [10:0] vpage; logic [10:0] hpaddr; } fill_exp_t;

    req_exp_t    req_q[$];
    fill_exp_t   fill_q[$];
    logic [10:0] inv_q[$];
    logic [10:0] sack_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int n_req_seen  = 0;
    int n_fill_seen = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_nonempty(input string tag, input int qsize);
        n_tests++;
        assert (qsize > 0) else begin
            n_fail++;
            $error("FAIL %s: observed transfer with 0 queued, expected at least 1", tag);
        end
    endtask

    always @(negedge clk) begin
        if (req_valid && !req_retry) begin
            req_exp_t e;
            n_req_seen++;
            chk_nonempty("req_unexpected", req_q.size());
            if (req_q.size() > 0) begin
                e = req_q.pop_front();
                chk("req_rid", 64'(req.rid), 64'(e.rid));
                chk("req_vpage", 64'(req.laddr[22:12]), 64'(e.vpage));
            end
        end
        if (fill_valid && !fill_retry) begin
            fill_exp_t f;
            n_fill_seen++;
            chk_nonempty("fill_unexpected", fill_q.size());
            if (fill_q.size() > 0) begin
                f = fill_q.pop_front();
                chk("fill_vpage", 64'(fill_vpage), 64'(f.vpage));
                chk("fill_hpaddr", 64'(fill_hpaddr), 64'(f.hpaddr));
            end
        end
        if (inv_valid && !inv_retry) begin
            chk_nonempty("inv_unexpected", inv_q.size());
            if (inv_q.size() > 0) chk("inv_hpaddr", 64'(inv_hpaddr), 64'(inv_q.pop_front()));
        end
        if (sack_valid && !sack_retry) begin
            chk_nonempty("sack_unexpected", sack_q.size());
            if (sack_q.size() > 0) chk("sack_hpaddr", 64'(sack.hpaddr), 64'(sack_q.pop_front()));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive_miss(input logic [10:0] v);
        miss_valid       = 1'b1;
        miss_laddr       = '0;
        miss_laddr[22:12] = v;
    endtask

    task automatic drive_ack(input logic [3:0] rid, input logic [10:0] hp);
        ack_valid  = 1'b1;
        ack.rid    = rid;
        ack.hpaddr = hp;
        ack.ppaddr = hp[2:0];
        ack.dctlbe = {2'b01, hp};
    endtask

    function automatic req_exp_t mk_req(input logic [3:0] rid, input logic [10:0] v);
        req_exp_t e;
        e.rid   = rid;
        e.vpage = v;
        return e;
    endfunction

    function automatic fill_exp_t mk_fill(input logic [10:0] v, input logic [10:0] hp);
        fill_exp_t f;
        f.vpage  = v;
        f.hpaddr = hp;
        return f;
    endfunction

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int fills_before;
        int reqs_before;

        reset = 1'b1;
        miss_valid = 1'b0; miss_laddr = '0;
        req_retry = 1'b0;
        ack_valid = 1'b0; ack = '0;
        fill_retry = 1'b0;
        snoop_valid = 1'b0; snoop = '0;
        inv_retry = 1'b0; sack_retry = 1'b0;

        // Reset state
        cyc(); cyc(); settle();
        chk("rst_req_valid", 64'(req_valid), 0);
        chk("rst_fill_valid", 64'(fill_valid), 0);
        chk("rst_inv_valid", 64'(inv_valid), 0);
        chk("rst_sack_valid", 64'(sack_valid), 0);
        chk("rst_err_ack", 64'(err_ack), 0);
        chk("rst_miss_retry", 64'(miss_retry), 0);
        chk("rst_snoop_retry", 64'(snoop_retry), 0);
        reset = 1'b0;

        // 1: single miss, 2-cycle request latency, fill
        drive_miss(11'h155);
        req_q.push_back(mk_req(4'd0, 11'h155));
        cyc();
        miss_valid = 1'b0; settle();
        chk("t1_req_not_yet", 64'(req_valid), 0);
        cyc(); settle();
        chk("t1_req_at_plus2", 64'(req_valid), 1);
        chk("t1_req_laddr", 64'(req.laddr), 64'(50'h155 << 12));
        cyc();
        drive_ack(4'd0, 11'h2AA);
        fill_q.push_back(mk_fill(11'h155, 11'h2AA));
        settle();
        chk("t1_fill_valid", 64'(fill_valid), 1);
        chk("t1_ack_retry", 64'(ack_retry), 0);
        chk("t1_fill_ppaddr", 64'(fill_ppaddr), 64'(3'h2));
        chk("t1_fill_dctlbe", 64'(fill_dctlbe), 64'(13'h0AAA));
        cyc();
        ack_valid = 1'b0; settle();
        chk("t1_fill_done", 64'(fill_valid), 0);

        // 2: fill all rids, fifth miss retried until rid 2 is freed
        for (int i = 0; i < 4; i++) begin
            drive_miss(11'(11'h100 + i));
            req_q.push_back(mk_req(4'(i), 11'(11'h100 + i)));
            settle();
            chk("t2_miss_accept", 64'(miss_retry), 0);
            cyc();
        end
        drive_miss(11'h104); settle();
        chk("t2_miss_full", 64'(miss_retry), 1);
        cyc(); cyc(); cyc();
        chk("t2_miss_still_full", 64'(miss_retry), 1);
        chk("t2_four_reqs", 64'(req_q.size()), 0);
        drive_ack(4'd2, 11'h022);
        fill_q.push_back(mk_fill(11'h102, 11'h022));
        settle();
        chk("t2_miss_retry_same_cycle", 64'(miss_retry), 1);
        cyc();
        ack_valid = 1'b0; settle();
        chk("t2_miss_after_free", 64'(miss_retry), 0);
        req_q.push_back(mk_req(4'd2, 11'h104));
        cyc();
        miss_valid = 1'b0;
        cyc(); cyc(); cyc();
        drive_ack(4'd0, 11'h010); fill_q.push_back(mk_fill(11'h100, 11'h010)); cyc();
        drive_ack(4'd1, 11'h011); fill_q.push_back(mk_fill(11'h101, 11'h011)); cyc();
        drive_ack(4'd3, 11'h013); fill_q.push_back(mk_fill(11'h103, 11'h013)); cyc();
        drive_ack(4'd2, 11'h012); fill_q.push_back(mk_fill(11'h104, 11'h012)); cyc();
        ack_valid = 1'b0;
        chk("t2_fills_drained", 64'(fill_q.size()), 0);

        // 3: back-to-back misses to the same vpage merge into one request
        reqs_before  = n_req_seen;
        fills_before = n_fill_seen;
        drive_miss(11'h010);
        req_q.push_back(mk_req(4'd0, 11'h010));
        cyc(); settle();
        chk("t3_merge_no_retry", 64'(miss_retry), 0);
        cyc();
        miss_valid = 1'b0;
        cyc(); cyc(); cyc();
        chk("t3_one_req", 64'(n_req_seen - reqs_before), 1);
        drive_ack(4'd0, 11'h0AB);
        fill_q.push_back(mk_fill(11'h010, 11'h0AB));
        cyc();
        ack_valid = 1'b0;
        cyc(); cyc();
        chk("t3_one_fill", 64'(n_fill_seen - fills_before), 1);

        // 4: snoop marks the waiting entry stale; first ack replays, second fills
        fills_before = n_fill_seen;
        drive_miss(11'h020);
        req_q.push_back(mk_req(4'd0, 11'h020));
        cyc();
        miss_valid = 1'b0;
        cyc(); cyc();
        snoop_valid = 1'b1; snoop.hpaddr = 11'h7FF;
        inv_q.push_back(11'h7FF); sack_q.push_back(11'h7FF);
        settle();
        chk("t4_snoop_accept", 64'(snoop_retry), 0);
        cyc();
        snoop_valid = 1'b0; settle();
        chk("t4_inv_valid", 64'(inv_valid), 1);
        chk("t4_snoop_busy", 64'(snoop_retry), 1);
        cyc(); cyc(); settle();
        chk("t4_sack_valid", 64'(sack_valid), 1);
        drive_ack(4'd0, 11'h333);
        req_q.push_back(mk_req(4'd0, 11'h020));
        settle();
        chk("t4_stale_no_fill", 64'(fill_valid), 0);
        chk("t4_stale_consumed", 64'(ack_retry), 0);
        cyc();
        ack_valid = 1'b0;
        cyc(); cyc(); cyc();
        chk("t4_replay_sent", 64'(req_q.size()), 0);
        drive_ack(4'd0, 11'h334);
        fill_q.push_back(mk_fill(11'h020, 11'h334));
        settle();
        chk("t4_second_fill", 64'(fill_valid), 1);
        cyc();
        ack_valid = 1'b0;
        chk("t4_fill_count", 64'(n_fill_seen - fills_before), 1);

        // 5a: fill_retry backpressures the ack for 3 cycles, single fill
        fills_before = n_fill_seen;
        drive_miss(11'h030);
        req_q.push_back(mk_req(4'd0, 11'h030));
        cyc();
        miss_valid = 1'b0;
        cyc(); cyc();
        drive_ack(4'd0, 11'h055);
        fill_retry = 1'b1;
        fill_q.push_back(mk_fill(11'h030, 11'h055));
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("t5_ack_held", 64'(ack_retry), 1);
            cyc();
        end
        fill_retry = 1'b0; settle();
        chk("t5_ack_release", 64'(ack_retry), 0);
        cyc();
        ack_valid = 1'b0;
        chk("t5_single_fill", 64'(n_fill_seen - fills_before), 1);

        // 5b: snoop accepted during a held ack blocks the fill until the sack is handed off
        fills_before = n_fill_seen;
        drive_miss(11'h040);
        req_q.push_back(mk_req(4'd0, 11'h040));
        cyc();
        miss_valid = 1'b0;
        cyc(); cyc();
        drive_ack(4'd0, 11'h066);
        fill_retry = 1'b1;
        snoop_valid = 1'b1; snoop.hpaddr = 11'h123;
        inv_q.push_back(11'h123); sack_q.push_back(11'h123);
        settle();
        chk("t5_snoop_with_held_ack", 64'(snoop_retry), 0);
        cyc();
        snoop_valid = 1'b0; fill_retry = 1'b0; settle();
        chk("t5_fill_blocked_inv", 64'(fill_valid), 0);
        chk("t5_ack_blocked_inv", 64'(ack_retry), 1);
        cyc(); settle();
        chk("t5_fill_blocked_sack", 64'(fill_valid), 0);
        cyc(); settle();
        chk("t5_stale_after_sack", 64'(fill_valid), 0);
        req_q.push_back(mk_req(4'd0, 11'h040));
        cyc();
        ack_valid = 1'b0;
        cyc(); cyc(); cyc();
        drive_ack(4'd0, 11'h067);
        fill_q.push_back(mk_fill(11'h040, 11'h067));
        cyc();
        ack_valid = 1'b0;
        chk("t5b_single_fill", 64'(n_fill_seen - fills_before), 1);

        // 6a: ack to a FREE rid raises a one-cycle err_ack
        drive_ack(4'd3, 11'h0EE); settle();
        chk("t6_err_no_fill", 64'(fill_valid), 0);
        cyc();
        ack_valid = 1'b0; settle();
        chk("t6_err_pulse", 64'(err_ack), 1);
        cyc(); settle();
        chk("t6_err_clear", 64'(err_ack), 0);

        // 6b: reset with two entries in WAIT drops everything
        drive_miss(11'h050);
        req_q.push_back(mk_req(4'd0, 11'h050));
        cyc();
        drive_miss(11'h051);
        req_q.push_back(mk_req(4'd1, 11'h051));
        cyc();
        miss_valid = 1'b0;
        cyc(); cyc(); cyc();
        drive_ack(4'd0, 11'h0F0);
        fill_retry = 1'b1; settle();
        chk("t6_fill_pending", 64'(fill_valid), 1);
        reset = 1'b1;
        cyc(); settle();
        chk("t6_rst_fill", 64'(fill_valid), 0);
        chk("t6_rst_req", 64'(req_valid), 0);
        chk("t6_rst_inv", 64'(inv_valid), 0);
        chk("t6_rst_sack", 64'(sack_valid), 0);
        chk("t6_rst_err", 64'(err_ack), 0);
        chk("t6_rst_miss_retry", 64'(miss_retry), 0);
        ack_valid = 1'b0; fill_retry = 1'b0; reset = 1'b0;
        cyc();
        fills_before = n_fill_seen;
        drive_ack(4'd1, 11'h0F1); settle();
        chk("t6_late_ack_no_fill", 64'(fill_valid), 0);
        cyc();
        ack_valid = 1'b0; settle();
        chk("t6_late_ack_err", 64'(err_ack), 1);
        cyc();

        chk("end_req_q", 64'(req_q.size()), 0);
        chk("end_fill_q", 64'(fill_q.size()), 0);
        chk("end_inv_q", 64'(inv_q.size()), 0);
        chk("end_sack_q", 64'(sack_q.size()), 0);
        chk("end_no_late_fill", 64'(n_fill_seen - fills_before), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
